dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the byte-addressed, big-endian data memory (`dataMem`). It lets two requesters share the single memory port: port 0 is the CPU load/store unit, port 1 is the debug/DMA loader. Each accepted request runs read, write or atomic swap as a fixed cycle sequence. The memory's own `swap` input is tied low; this block builds swap from a read followed by a write.

## Interface
- `ADDR_W`, 32, byte-address width passed to memory unchanged.
- `DATA_W`, 32, data word width.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request pending on port 0 / 1.
- `req0_op`, `req1_op`  in  2  00 read, 01 write, 10 swap, 11 treated as read.
- `req0_addr`, `req1_addr`  in  ADDR_W  byte address.
- `req0_wdata`, `req1_wdata`  in  DATA_W  write / swap data.
- `req0_ready`, `req1_ready`  out  1  one-cycle accept pulse.
- `req0_done`, `req1_done`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  DATA_W  read data, or old data for swap; valid with `doneN`, held until the next completion.
- `mem_addr`  out  ADDR_W  to memory `addr`.
- `mem_wdata`  out  DATA_W  to memory `dat_in`.
- `mem_we`  out  1  to memory `we`.
- `mem_rdata`  in  DATA_W  from memory `dat_out`; combinational read of `mem_addr`.

## Operation
- FSM states: IDLE, ACCESS, SWAP_WR, DONE.
- **IDLE:** if any `reqN_valid` is high, grant one port and assert that `reqN_ready` this cycle. At the clock edge, latch the granted port's op, addr and wdata, then go to ACCESS.
- **Grant rule:**
  - If only one port is valid, grant that port.
  - If both are valid, grant the port not granted last (round-robin pointer).
  - The pointer resets to "port 0 first" and updates only on a grant.
- **ACCESS:** `mem_addr` = latched addr.
  - Read: `mem_we`=0. Capture `mem_rdata` into `rsp_rdata` at the edge, then go to DONE.
  - Write: `mem_we`=1, `mem_wdata` = latched wdata for exactly this cycle, then go to DONE. `rsp_rdata` is unchanged.
  - Swap: `mem_we`=0. Capture `mem_rdata` (old value) into `rsp_rdata`, then go to SWAP_WR.
- **SWAP_WR:** same `mem_addr`, `mem_we`=1, `mem_wdata` = latched wdata, then go to DONE.
- **DONE:** pulse `doneN` for the granted port, then go to IDLE. The pointer records the granted port.
- `mem_we` is high only in ACCESS (write) or SWAP_WR. `mem_addr` and `mem_wdata` hold their latched values outside those states.
- **Requester rules:**
  - Hold `valid` and all fields stable until `ready` is seen.
  - Dropping `valid` before `ready` is a legal withdrawal and nothing is issued.
  - Request fields are ignored after the grant.
- No alignment check. addr+1..+3 byte sequencing and 32-bit wrap are the memory's job, and `mem_addr` passes through bit-exact.
- Reset values:
  - state IDLE, pointer = port 0.
  - `reqN_ready`=0, `reqN_done`=0, `mem_we`=0.
  - `mem_addr`=0, `mem_wdata`=0, `rsp_rdata`=0.

## Timing
- Request accepted in cycle T (`ready`=1 in T). ACCESS is T+1.
- Read/write: `done` in T+2. Swap: SWAP_WR is T+2 and `done` is T+3.
- IDLE is re-entered at T+3 (read/write) or T+4 (swap). The earliest next `ready` is that cycle.
- Sustained rate: one read/write per 3 cycles, one swap per 4 cycles.
- No back-to-back grants. A request arriving during a busy cycle waits, and `ready` stays 0.
- Swap is atomic: the other port cannot be granted between the read and the write.
- **Reset mid-operation:** `rst` sampled high aborts immediately and everything returns to reset values next cycle.
  - A SWAP_WR pending at that edge is never issued.
  - A write whose `mem_we` cycle already completed stays in memory.
  - No `done` pulse for the aborted request.
- **Simultaneous valid at reset release:** port 0 wins the first grant and port 1 wins the next.

## Test plan
- Port 0 write addr 0x10 data 0xDEADBEEF, then read 0x10 → `ready` at T, `mem_we`=1 only at T+1, read `done` at T'+2 with `rsp_rdata`=0xDEADBEEF.
- Swap on port 1, addr 0x20 (holding 0x11223344), wdata 0xCAFEF00D → `done` at T+3, `rsp_rdata`=0x11223344, a subsequent read returns 0xCAFEF00D.
- Both ports hold valid reads continuously → grants alternate 0,1,0,1, and each port gets `ready` exactly once per 6 cycles.
- Port 0 swap issued while port 1 holds a write to the same address → port 1 stays not-ready until port 0's `done`. Final memory value is port 1's data; port 0's `rsp_rdata` is the pre-swap value.
- `rst` asserted during ACCESS of a swap → no `mem_we` pulse and no `done`; all outputs zero; the memory word is unchanged.
- `valid` dropped before `ready` while busy, plus op 11 → the withdrawn request is never issued, and op 11 behaves exactly as a read (`mem_we` stays 0).

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter and sequencer in front of the byte-addressed, big-endian
// data memory. Port 0 is the CPU load/store unit and port 1 is the debug/DMA
// loader. Each accepted request runs as a fixed sequence:
//   read/write: IDLE -> ACCESS -> DONE
//   swap:       IDLE -> ACCESS (read old) -> SWAP_WR (write new) -> DONE
// Swap is built here from a read followed by a write, so the memory's own
// swap input stays tied low outside this block.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   reqN_valid/op/addr/wdata   request from port N (op: 00 rd, 01 wr, 10 swap, 11 rd)
//   reqN_ready                 one-cycle accept pulse (combinational in IDLE)
//   reqN_done                  one-cycle completion pulse
//   rsp_rdata                  read data / pre-swap data, held until next capture
//   mem_addr, mem_wdata        latched request address and data to memory
//   mem_we                     memory write enable
//   mem_rdata                  combinational memory read data
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [1:0]        req0_op,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic [1:0]        req1_op,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              req0_done,
  output logic              req1_done,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    SWAP_WR = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [1:0]        op_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              port_r;      // port owning the operation in flight
  logic              last_r;      // port granted most recently
  logic              any_valid_s;
  logic              grant_s;     // port that would be granted this cycle
  logic              is_write_s;
  logic              is_swap_s;

  // Round-robin grant selection and decode of the latched opcode
  always_comb begin
    any_valid_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    // op 11 falls through as a read
    is_write_s = (op_r == 2'b01);
    is_swap_s  = (op_r == 2'b10);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state sequencing
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_valid_s) begin
          state_next_s = ACCESS;
        end else begin
          state_next_s = IDLE;
        end
      end
      ACCESS: begin
        if (is_swap_s) begin
          state_next_s = SWAP_WR;
        end else begin
          state_next_s = DONE;
        end
      end
      SWAP_WR: state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Handshake and memory-control decode. Ready is gated by rst so a request
  // is never told it was accepted on an edge where nothing gets latched.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((state_r == IDLE) && !rst && any_valid_s) begin
      req0_ready = ~grant_s;
      req1_ready = grant_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    req0_done = (state_r == DONE) && !port_r;
    req1_done = (state_r == DONE) && port_r;
    mem_we    = ((state_r == ACCESS) && is_write_s) || (state_r == SWAP_WR);
  end

  // Request latch, read-data capture and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r    <= 2'b00;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      rdata_r <= {DATA_W{1'b0}};
      port_r  <= 1'b0;
      last_r  <= 1'b1;  // "port 1 was last" so port 0 wins the first tie
    end else begin
      case (state_r)
        IDLE: begin
          if (any_valid_s) begin
            port_r  <= grant_s;
            last_r  <= grant_s;
            op_r    <= grant_s ? req1_op    : req0_op;
            addr_r  <= grant_s ? req1_addr  : req0_addr;
            wdata_r <= grant_s ? req1_wdata : req0_wdata;
          end
        end
        ACCESS: begin
          // read and swap both capture; write leaves the response untouched
          if (!is_write_s) begin
            rdata_r <= mem_rdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign rsp_rdata = rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a byte-wide big-endian memory model sits on the
// memory port, directed requests are driven on both ports, and a monitor on
// the falling edge pops per-port expectation queues on every done pulse.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_addr, req1_addr;
  logic [31:0] req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        req0_done, req1_done;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_done(req0_done), .req1_done(req1_done),
    .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Big-endian byte memory, 256 bytes, address wraps within the model
  logic [7:0] mem_b [0:255];
  assign mem_rdata = {mem_b[mem_addr[7:0]], mem_b[mem_addr[7:0] + 8'd1],
                      mem_b[mem_addr[7:0] + 8'd2], mem_b[mem_addr[7:0] + 8'd3]};
  always @(posedge clk) begin
    if (mem_we) begin
      mem_b[mem_addr[7:0]]        <= mem_wdata[31:24];
      mem_b[mem_addr[7:0] + 8'd1] <= mem_wdata[23:16];
      mem_b[mem_addr[7:0] + 8'd2] <= mem_wdata[15:8];
      mem_b[mem_addr[7:0] + 8'd3] <= mem_wdata[7:0];
    end
  end

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {mem_b[a], mem_b[a + 8'd1], mem_b[a + 8'd2], mem_b[a + 8'd3]};
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] w);
    mem_b[a]        <= w[31:24];
    mem_b[a + 8'd1] <= w[23:16];
    mem_b[a + 8'd2] <= w[15:8];
    mem_b[a + 8'd3] <= w[7:0];
  endtask

  // Scoreboard
  typedef struct {
    logic [31:0] rdata;
    int          lat;
    int          rdy;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  int n_checks = 0;
  int n_fail   = 0;
  int we_count = 0;
  int last_we_cyc = -1;
  int done_cnt = 0;
  int gl_port[$];
  int gl_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: grant log, write-enable log, done-driven scoreboard compare
  always @(negedge clk) begin
    if (!rst) begin
      if (req0_ready && req1_ready) check("dual_ready", 32'd1, 32'd0);
      if (req0_ready) begin gl_port.push_back(0); gl_cyc.push_back(cyc); end
      if (req1_ready) begin gl_port.push_back(1); gl_cyc.push_back(cyc); end
      if (mem_we) begin we_count++; last_we_cyc = cyc; end
      if (req0_done) begin
        done_cnt++;
        if (q0.size() == 0) begin
          check("unexpected_done0", 32'd1, 32'd0);
        end else begin
          e0 = q0.pop_front();
          check("done0_rdata", rsp_rdata, e0.rdata);
          check("done0_latency", cyc - e0.rdy, e0.lat);
        end
      end
      if (req1_done) begin
        done_cnt++;
        if (q1.size() == 0) begin
          check("unexpected_done1", 32'd1, 32'd0);
        end else begin
          e1 = q1.pop_front();
          check("done1_rdata", rsp_rdata, e1.rdata);
          check("done1_latency", cyc - e1.rdy, e1.lat);
        end
      end
    end
  end

  task automatic set_req(input int p, input logic v, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      req0_valid = v; req0_op = op; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_op = op; req1_addr = a; req1_wdata = d;
    end
  endtask

  function automatic logic get_ready(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  task automatic push_exp(input int p, input logic [31:0] rd, input int lat, input int rdy);
    exp_t e;
    e.rdata = rd; e.lat = lat; e.rdy = rdy;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Raise a request, wait (bounded) for ready, then drop valid after the grant edge.
  // Returns #1 into the ACCESS cycle.
  task automatic issue(input int p, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd,
                       input int lat, input bit push);
    bit got = 1'b0;
    set_req(p, 1'b1, op, a, d);
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (get_ready(p)) begin
        got = 1'b1;
        if (push) push_exp(p, exp_rd, lat, cyc);
      end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    set_req(p, 1'b0, op, a, d);
  endtask

  // Keep an already-raised read valid across n grants, then drop it
  task automatic hold_reads(input int p, input logic [31:0] a, input logic [31:0] exp_rd, input int n);
    for (int i = 0; i < n; i++) begin
      bit got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
        @(negedge clk);
        if (get_ready(p)) begin
          got = 1'b1;
          push_exp(p, exp_rd, 2, cyc);
        end
      end
      if (!got) check("hold_ready_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    set_req(p, 1'b0, 2'b00, a, 32'h0);
  endtask

  task automatic wait_quiet();
    for (int k = 0; k < 40 && (q0.size() + q1.size()) != 0; k++) @(negedge clk);
    check("drain_timeout", q0.size() + q1.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_ready0", req0_ready, 32'd0);
    check("rst_ready1", req1_ready, 32'd0);
    check("rst_done0", req0_done, 32'd0);
    check("rst_done1", req1_done, 32'd0);
    check("rst_mem_we", mem_we, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, rel, we_b, done_b;
    rst = 1'b1;
    set_req(0, 1'b0, 2'b00, 32'h0, 32'h0);
    set_req(1, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
    preload(8'h20, 32'h11223344);
    preload(8'h30, 32'hA5A5A5A5);
    preload(8'h40, 32'h0BADF00D);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read back on port 0
    issue(0, 2'b01, 32'h10, 32'hDEADBEEF, 32'h0, 2, 1'b1);
    wait_quiet();
    check("write_we_count", we_count, 32'd1);
    check("write_we_cycle", last_we_cyc, gl_cyc[gl_cyc.size() - 1] + 1);
    check("mem_0x10", word_at(8'h10), 32'hDEADBEEF);
    issue(0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 2, 1'b1);
    wait_quiet();

    // Swap on port 1, then read back the new value
    issue(1, 2'b10, 32'h20, 32'hCAFEF00D, 32'h11223344, 3, 1'b1);
    wait_quiet();
    check("swap_mem_0x20", word_at(8'h20), 32'hCAFEF00D);
    check("swap_we_count", we_count, 32'd2);
    issue(0, 2'b00, 32'h20, 32'h0, 32'hCAFEF00D, 2, 1'b1);
    wait_quiet();

    // Both ports valid through reset release: strict alternation from port 0
    rst = 1'b1;
    set_req(0, 1'b1, 2'b00, 32'h10, 32'h0);
    set_req(1, 1'b1, 2'b00, 32'h20, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("ready_gated_in_rst", {req0_ready, req1_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rel = cyc;
    s = gl_port.size();
    fork
      hold_reads(0, 32'h10, 32'hDEADBEEF, 3);
      hold_reads(1, 32'h20, 32'hCAFEF00D, 3);
    join
    wait_quiet();
    check("rr_grant_count", gl_port.size() - s, 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (s + i < gl_port.size()) begin
        check("rr_port", gl_port[s + i], i % 2);
        check("rr_cycle", gl_cyc[s + i], rel + 3 * i);
      end
    end

    // Port 0 swap vs port 1 write to the same word: swap is atomic
    s = gl_port.size();
    fork
      issue(0, 2'b10, 32'h30, 32'h01020304, 32'hA5A5A5A5, 3, 1'b1);
      issue(1, 2'b01, 32'h30, 32'h55667788, 32'hA5A5A5A5, 2, 1'b1);
    join
    wait_quiet();
    if (gl_port.size() >= s + 2) begin
      check("atomic_first_port", gl_port[s], 32'd0);
      check("atomic_second_port", gl_port[s + 1], 32'd1);
      check("atomic_gap", gl_cyc[s + 1] - gl_cyc[s], 32'd4);
    end else begin
      check("atomic_grant_count", gl_port.size() - s, 32'd2);
    end
    check("atomic_mem_0x30", word_at(8'h30), 32'h55667788);
    check("atomic_we_count", we_count, 32'd4);

    // Reset during ACCESS of a swap: nothing written, no done
    we_b = we_count;
    done_b = done_cnt;
    issue(0, 2'b10, 32'h40, 32'hFFFFFFFF, 32'h0, 3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    repeat (6) @(posedge clk);
    #1;
    check("abort_we_count", we_count, we_b);
    check("abort_done_count", done_cnt, done_b);
    check("abort_mem_0x40", word_at(8'h40), 32'h0BADF00D);

    // Withdrawn request while busy, then op 11 as a read
    s = gl_port.size();
    we_b = we_count;
    issue(0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 2, 1'b1);
    set_req(1, 1'b1, 2'b01, 32'h50, 32'h12345678);
    @(posedge clk); #1;
    set_req(1, 1'b0, 2'b01, 32'h50, 32'h12345678);
    wait_quiet();
    check("withdraw_grants", gl_port.size() - s, 32'd1);
    check("withdraw_mem_0x50", word_at(8'h50), 32'h00000000);
    issue(1, 2'b11, 32'h10, 32'h0, 32'hDEADBEEF, 2, 1'b1);
    wait_quiet();
    check("op11_port", gl_port[gl_port.size() - 1], 32'd1);
    check("op11_we_count", we_count, we_b);

    check("pending_q0", q0.size(), 32'd0);
    check("pending_q1", q1.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
